// File: rtl/skin_box_tracker.sv
// Skin-colour classifier and per-frame bounding-box tracker for a YCbCr444 stream.
// Emits a 1-cycle-latency skin mask and publishes count/box once per frame at vsync fall.
module skin_box_tracker #(
    parameter logic [7:0]  CB_MIN     = 8'd77,
    parameter logic [7:0]  CB_MAX     = 8'd127,
    parameter logic [7:0]  CR_MIN     = 8'd133,
    parameter logic [7:0]  CR_MAX     = 8'd173,
    parameter int unsigned MIN_PIXELS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [7:0]  per_img_Y,
    input  logic [7:0]  per_img_Cb,
    input  logic [7:0]  per_img_Cr,
    input  logic [10:0] per_setx,
    input  logic [9:0]  per_sety,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_bit,
    output logic [10:0] post_setx,
    output logic [9:0]  post_sety,
    output logic [10:0] box_x_min,
    output logic [10:0] box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max,
    output logic [20:0] skin_count,
    output logic        box_valid,
    output logic        box_update
);

    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 21;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    state_t         state;
    logic           vsync_d;
    logic           armed;
    logic [XW-1:0]  acc_x_min;
    logic [XW-1:0]  acc_x_max;
    logic [YW-1:0]  acc_y_min;
    logic [YW-1:0]  acc_y_max;
    logic [CW-1:0]  acc_cnt;

    logic           qualified_c;
    logic           is_skin_c;
    logic           skin_hit_c;
    logic           frame_start_c;
    logic           frame_end_c;
    logic [XW-1:0]  nxt_x_min_c;
    logic [XW-1:0]  nxt_x_max_c;
    logic [YW-1:0]  nxt_y_min_c;
    logic [YW-1:0]  nxt_y_max_c;
    logic [CW-1:0]  nxt_cnt_c;

    // Luma only travels with the stream upstream; it plays no part in classification.
    logic unused_luma_c;
    assign unused_luma_c = ^per_img_Y;

    // Pixel qualification, skin window and frame edge detection.
    // armed blocks a rise seen right after reset so a partially observed frame is never published.
    assign qualified_c   = per_frame_vsync & per_frame_href & per_frame_clken;
    assign is_skin_c     = (per_img_Cb >= CB_MIN) && (per_img_Cb <= CB_MAX) &&
                           (per_img_Cr >= CR_MIN) && (per_img_Cr <= CR_MAX);
    assign skin_hit_c    = qualified_c & is_skin_c;
    assign frame_start_c = per_frame_vsync & ~vsync_d & armed;
    assign frame_end_c   = ~per_frame_vsync & vsync_d;

    // Next accumulator values: reload on frame start, then fold in the current skin pixel.
    always_comb begin
        nxt_x_min_c = acc_x_min;
        nxt_x_max_c = acc_x_max;
        nxt_y_min_c = acc_y_min;
        nxt_y_max_c = acc_y_max;
        nxt_cnt_c   = acc_cnt;
        if (frame_start_c) begin
            nxt_x_min_c = '1;
            nxt_x_max_c = '0;
            nxt_y_min_c = '1;
            nxt_y_max_c = '0;
            nxt_cnt_c   = '0;
        end
        if (skin_hit_c) begin
            if (per_setx < nxt_x_min_c) nxt_x_min_c = per_setx;
            if (per_setx > nxt_x_max_c) nxt_x_max_c = per_setx;
            if (per_sety < nxt_y_min_c) nxt_y_min_c = per_sety;
            if (per_sety > nxt_y_max_c) nxt_y_max_c = per_sety;
            if (nxt_cnt_c != CNT_MAX)   nxt_cnt_c   = nxt_cnt_c + CW'(1);
        end
    end

    // One-cycle mask pipeline with the sync/coordinate sideband.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_bit     <= 1'b0;
            post_setx        <= '0;
            post_sety        <= '0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_bit     <= skin_hit_c;
            post_setx        <= per_setx;
            post_sety        <= per_sety;
        end
    end

    // Vsync history, arming and the per-frame accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            armed     <= 1'b0;
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
            acc_cnt   <= '0;
        end else begin
            vsync_d   <= per_frame_vsync;
            armed     <= armed | ~per_frame_vsync;
            acc_x_min <= nxt_x_min_c;
            acc_x_max <= nxt_x_max_c;
            acc_y_min <= nxt_y_min_c;
            acc_y_max <= nxt_y_max_c;
            acc_cnt   <= nxt_cnt_c;
        end
    end

    // Frame FSM with registered publish of count, box and the update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            box_update <= 1'b0;
            box_valid  <= 1'b0;
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            skin_count <= '0;
        end else begin
            box_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start_c) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (frame_end_c) begin
                        state      <= PUBLISH;
                        box_update <= 1'b1;
                        skin_count <= acc_cnt;
                        if (acc_cnt >= MIN_CNT) begin
                            box_valid <= 1'b1;
                            box_x_min <= acc_x_min;
                            box_x_max <= acc_x_max;
                            box_y_min <= acc_y_min;
                            box_y_max <= acc_y_max;
                        end else begin
                            box_valid <= 1'b0;
                        end
                    end
                end
                PUBLISH: begin
                    state <= per_frame_vsync ? ACTIVE : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
